// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_stage
//  Purpose  : IF/ID pipeline register with load-use hazard detection, PC
//             freeze, decode bubble request and redirect flush.
//  Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               flush,
    input  logic               ex_mem_read,
    input  logic [4:0]         ex_rt,
    output logic               PC_write,
    output logic [INSTR_W-1:0] instr_id,
    output logic               valid_id,
    output logic [5:0]         opcode_id,
    output logic [4:0]         rs_id,
    output logic [4:0]         rt_id,
    output logic [4:0]         rd_id,
    output logic [15:0]        imm_id,
    output logic               id_bubble,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_valid;
    logic w_rt_match;
    logic w_load_use;

    // Only EMPTY means "no real instruction held"; RUN and STALL both hold one.
    assign w_valid    = (r_state != ST_EMPTY);
    assign w_rt_match = (ex_rt == r_instr[25:21]) | (ex_rt == r_instr[20:16]);
    assign w_load_use = w_valid & ex_mem_read & (ex_rt != 5'd0) & w_rt_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_instr     <= NOP_INSTR;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_instr <= NOP_INSTR;
        end else if (w_load_use) begin
            // Hold the instruction; the PC is frozen by the same decision.
            r_state <= ST_STALL;
            if (!(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end else begin
            r_state <= ST_RUN;
            r_instr <= instr_in;
        end
    end

    assign PC_write  = ~w_load_use | flush;
    assign id_bubble = w_load_use | ~w_valid;

    assign instr_id  = r_instr;
    assign valid_id  = w_valid;
    assign stall_cnt = r_stall_cnt;
    assign opcode_id = r_instr[31:26];
    assign rs_id     = r_instr[25:21];
    assign rt_id     = r_instr[20:16];
    assign rd_id     = r_instr[15:11];
    assign imm_id    = r_instr[15:0];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_id_stage
//  Purpose  : Directed self-checking bench for if_id_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        PC_write;
    logic [31:0] instr_id;
    logic        valid_id;
    logic [5:0]  opcode_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [4:0]  rd_id;
    logic [15:0] imm_id;
    logic        id_bubble;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_fail;

    if_id_stage #(
        .INSTR_W  (32),
        .NOP_INSTR(32'h0),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_in   (instr_in),
        .flush      (flush),
        .ex_mem_read(ex_mem_read),
        .ex_rt      (ex_rt),
        .PC_write   (PC_write),
        .instr_id   (instr_id),
        .valid_id   (valid_id),
        .opcode_id  (opcode_id),
        .rs_id      (rs_id),
        .rt_id      (rt_id),
        .rd_id      (rd_id),
        .imm_id     (imm_id),
        .id_bubble  (id_bubble),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_in = 32'h0; flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", instr_id, 32'h0); end
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_id); end
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL reset_pcw: got %b expected 1", PC_write); end
        n_checks++; if (id_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b expected 1", id_bubble); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", stall_cnt); end
    endtask

    task automatic test_flow();
        @(negedge clk);
        rst_n = 1'b1; instr_in = 32'h00E64000;
        tick();
        n_checks++; if (instr_id !== 32'h00E64000) begin n_fail++; $display("FAIL flow_instr: got %h expected 00e64000", instr_id); end
        n_checks++; if (opcode_id !== 6'd0) begin n_fail++; $display("FAIL flow_opcode: got %0d expected 0", opcode_id); end
        n_checks++; if (rs_id !== 5'd7) begin n_fail++; $display("FAIL flow_rs: got %0d expected 7", rs_id); end
        n_checks++; if (rt_id !== 5'd6) begin n_fail++; $display("FAIL flow_rt: got %0d expected 6", rt_id); end
        n_checks++; if (rd_id !== 5'd8) begin n_fail++; $display("FAIL flow_rd: got %0d expected 8", rd_id); end
        n_checks++; if (imm_id !== 16'h4000) begin n_fail++; $display("FAIL flow_imm: got %h expected 4000", imm_id); end
        n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL flow_valid: got %b expected 1", valid_id); end
        n_checks++; if (id_bubble !== 1'b0) begin n_fail++; $display("FAIL flow_bubble: got %b expected 0", id_bubble); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd6; instr_in = 32'h01095020;
        #1;
        n_checks++; if (PC_write !== 1'b0) begin n_fail++; $display("FAIL lu_pcw: got %b expected 0", PC_write); end
        n_checks++; if (id_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble: got %b expected 1", id_bubble); end
        tick();
        n_checks++; if (instr_id !== 32'h00E64000) begin n_fail++; $display("FAIL lu_hold: got %h expected 00e64000", instr_id); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %h expected 0001", stall_cnt); end
        n_checks++; if (valid_id !== 1'b1) begin n_fail++; $display("FAIL lu_valid: got %b expected 1", valid_id); end
        @(negedge clk);
        ex_mem_read = 1'b0;
        #1;
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL lu_release_pcw: got %b expected 1", PC_write); end
        tick();
        n_checks++; if (instr_id !== 32'h01095020) begin n_fail++; $display("FAIL lu_next: got %h expected 01095020", instr_id); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_after: got %h expected 0001", stall_cnt); end
    endtask

    task automatic test_no_false_stall();
        @(negedge clk);
        instr_in = 32'h00E64000;
        tick();
        // ex_rt=0 matches nothing real; rs=7, rt=6 still in the held instruction
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd0; instr_in = 32'h00E6FFFF;
        #1;
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL nfs_r0_pcw: got %b expected 1", PC_write); end
        tick();
        n_checks++; if (instr_id !== 32'h00E6FFFF) begin n_fail++; $display("FAIL nfs_r0_instr: got %h expected 00e6ffff", instr_id); end
        @(negedge clk);
        ex_rt = 5'd9; instr_in = 32'h00E61234;
        #1;
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL nfs_r9_pcw: got %b expected 1", PC_write); end
        tick();
        n_checks++; if (instr_id !== 32'h00E61234) begin n_fail++; $display("FAIL nfs_r9_instr: got %h expected 00e61234", instr_id); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL nfs_cnt: got %h expected 0001", stall_cnt); end
    endtask

    task automatic test_flush_vs_stall();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd7; flush = 1'b1; instr_in = 32'hDEADBEEF;
        #1;
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL fl_pcw: got %b expected 1", PC_write); end
        tick();
        n_checks++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL fl_instr: got %h expected 00000000", instr_id); end
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b expected 0", valid_id); end
        n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL fl_cnt: got %h expected 0001", stall_cnt); end
        n_checks++; if (id_bubble !== 1'b1) begin n_fail++; $display("FAIL fl_bubble: got %b expected 1", id_bubble); end
        @(negedge clk);
        flush = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    endtask

    task automatic test_saturation_reset();
        @(negedge clk);
        instr_in = 32'h00E64000;
        tick();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rt = 5'd6;
        // count is 1; 0xFFFD held-hazard edges bring it to 0xFFFE
        for (int i = 0; i < 32'hFFFD; i++) @(posedge clk);
        #1;
        n_checks++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload: got %h expected fffe", stall_cnt); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt%0d: got %h expected ffff", k, stall_cnt); end
        end
        n_checks++; if (instr_id !== 32'h00E64000) begin n_fail++; $display("FAIL sat_hold: got %h expected 00e64000", instr_id); end
        n_checks++; if (PC_write !== 1'b0) begin n_fail++; $display("FAIL sat_pcw: got %b expected 0", PC_write); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL arst_instr: got %h expected 00000000", instr_id); end
        n_checks++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", valid_id); end
        n_checks++; if (PC_write !== 1'b1) begin n_fail++; $display("FAIL arst_pcw: got %b expected 1", PC_write); end
        n_checks++; if (id_bubble !== 1'b1) begin n_fail++; $display("FAIL arst_bubble: got %b expected 1", id_bubble); end
        n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_cnt: got %h expected 0000", stall_cnt); end
        @(negedge clk);
        rst_n = 1'b1; ex_mem_read = 1'b0; ex_rt = 5'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_flow();
        test_load_use();
        test_no_false_stall();
        test_flush_vs_stall();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
